// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB3 initiator driven by a valid/ready command stream
//
// Purpose:
//   Turns one command (read or write) into one APB3 SETUP/ACCESS transfer and
//   returns exactly one response carrying read data and an error flag.
//   Misaligned commands are answered with an error and never reach the bus.
//   An ACCESS phase that sees PREADY low for TIMEOUT_CYCLES cycles is
//   terminated with an error so a hung slave cannot stall the initiator.
//
// Ports:
//   PCLK        bus clock, all state changes on the rising edge
//   PRESET      synchronous active-high reset
//   cmd_*       command stream (valid/ready), cmd_ready high only in IDLE
//   rsp_*       response stream (valid/ready), rdata/err held until consumed
//   P*          APB3 initiator signals, all registered
//
// Parameters:
//   ADDR_W          address width (cmd_addr, PADDR), at least 2
//   DATA_W          data width
//   TIMEOUT_CYCLES  ACCESS cycles with PREADY low before forced error (>= 1)

module apb_cmd_master #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    // command stream
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response stream
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // APB3 initiator
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // Wide enough to hold TIMEOUT_CYCLES itself.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_psel;
    logic                w_psel_nxt;
    logic                r_penable;
    logic                w_penable_nxt;
    logic                r_pwrite;
    logic                w_pwrite_nxt;
    logic [ADDR_W-1:0]   r_paddr;
    logic [ADDR_W-1:0]   w_paddr_nxt;
    logic [DATA_W-1:0]   r_pwdata;
    logic [DATA_W-1:0]   w_pwdata_nxt;

    logic                r_rsp_valid;
    logic                w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [DATA_W-1:0]   w_rsp_rdata_nxt;
    logic                r_rsp_err;
    logic                w_rsp_err_nxt;

    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_timeout;
    logic                w_cmd_hs;
    logic                w_aligned;

    // cmd_ready is a pure decode of state so the command source sees it in
    // the same cycle the FSM returns to IDLE; forced low while in reset.
    assign cmd_ready = (r_state == S_IDLE) && !PRESET;
    assign w_cmd_hs  = cmd_valid && cmd_ready;
    assign w_aligned = (cmd_addr[1:0] == 2'b00);

    // The wait-state count including the current low-PREADY cycle; reaching
    // TIMEOUT_CYCLES here means this is the last ACCESS cycle we tolerate.
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Next-state and next-output decode. Every register holds by default.
    always_comb begin
        w_state_nxt     = r_state;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_cmd_hs) begin
                    if (w_aligned) begin
                        w_state_nxt   = S_SETUP;
                        w_psel_nxt    = 1'b1;
                        w_penable_nxt = 1'b0;
                        w_paddr_nxt   = cmd_addr;
                        w_pwrite_nxt  = cmd_write;
                        // Reads drive zero on PWDATA rather than stale data.
                        w_pwdata_nxt  = cmd_write ? cmd_wdata : '0;
                        w_cnt_nxt     = '0;
                    end else begin
                        // Misaligned: answer directly, bus stays untouched.
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end
                end
            end

            S_SETUP: begin
                w_state_nxt   = S_ACCESS;
                w_penable_nxt = 1'b1;
            end

            S_ACCESS: begin
                if (PREADY) begin
                    w_state_nxt     = S_RESP;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = PSLVERR;
                    // Read data is returned even when PSLVERR is set.
                    w_rsp_rdata_nxt = r_pwrite ? '0 : PRDATA;
                end else if (w_timeout) begin
                    w_state_nxt     = S_RESP;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_cnt_nxt       = w_cnt_inc;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs. Reset abandons any transfer or pending
    // response; nothing is replayed afterwards.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= S_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - self-checking bench for apb_cmd_master

module tb_apb_cmd_master;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Peripheral: 64-word register file with programmable wait states / error.
    bit [31:0] mem [64];
    int        sl_wait = 0;
    bit        sl_err  = 1'b0;
    int        sl_cnt  = 0;

    assign PREADY  = (sl_cnt >= sl_wait);
    assign PSLVERR = sl_err;
    assign PRDATA  = mem[PADDR[7:2]];

    always @(posedge PCLK) begin
        sl_cnt <= (PSEL && PENABLE) ? sl_cnt + 1 : 0;
        if (!PRESET && PSEL && PENABLE && PREADY && PWRITE && !PSLVERR)
            mem[PADDR[7:2]] <= PWDATA;
    end

    // Protocol watch: SETUP only from idle bus, ACCESS only after PSEL was high.
    bit mon_prev_psel = 1'b0;
    always @(negedge PCLK) begin
        if (PSEL === 1'b1 || PENABLE === 1'b1) begin
            n_checks++;
            if ((PENABLE && !PSEL) || (PSEL && (PENABLE != mon_prev_psel)))
                $display("FAIL apb_phase t=%0t: PSEL=%b PENABLE=%b prev_PSEL=%b, required SETUP then ACCESS", $time, PSEL, PENABLE, mon_prev_psel);
            else
                n_pass++;
        end
        mon_prev_psel = (PSEL === 1'b1);
    end

    // Reference model: expected response from the command and slave behaviour.
    bit [31:0] ref_mem [64];
    int        exp_lat, exp_setup, exp_access;
    logic      exp_err;
    logic [31:0] exp_rdata;

    task automatic model(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                         input int waits, input bit serr);
        bit to;
        if (addr[1:0] != 2'b00) begin
            exp_lat = 1; exp_setup = 0; exp_access = 0; exp_err = 1'b1; exp_rdata = '0;
        end else begin
            to         = (waits >= TO);
            exp_access = to ? TO : waits + 1;
            exp_lat    = 2 + exp_access;
            exp_setup  = 1;
            exp_err    = to || serr;
            exp_rdata  = (to || wr) ? 32'd0 : ref_mem[addr[7:2]];
            if (wr && !to && !serr) ref_mem[addr[7:2]] = wdata;
        end
    endtask

    // Driver: issues one command, records what the bus and response did.
    int          obs_lat, obs_setup, obs_access, obs_hs_wait;
    bit          obs_addr_ok, obs_hold_ok;
    logic [31:0] obs_pwdata, obs_rdata;
    logic        obs_pwrite, obs_err, obs_post_valid, obs_post_ready;

    task automatic run_cmd(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                           input int waits, input bit serr, input int hold);
        sl_wait = waits; sl_err = serr;
        rsp_ready = (hold == 0);
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
        obs_hs_wait = 0; obs_setup = 0; obs_access = 0; obs_addr_ok = 1'b1; obs_hold_ok = 1'b1;
        obs_pwdata = '0; obs_pwrite = 1'b0; obs_lat = -1;
        while (cmd_ready !== 1'b1 && obs_hs_wait < 10) begin
            @(posedge PCLK); #1; obs_hs_wait++;
        end
        @(posedge PCLK); #1;
        cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = 8'($urandom); cmd_write = 1'($urandom);
        for (int k = 1; k <= 40; k++) begin
            if (PSEL === 1'b1 && PADDR !== addr) obs_addr_ok = 1'b0;
            if (PSEL === 1'b1 && PENABLE === 1'b0) obs_setup++;
            if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                obs_access++; obs_pwdata = PWDATA; obs_pwrite = PWRITE;
            end
            if (rsp_valid === 1'b1) begin obs_lat = k; break; end
            @(posedge PCLK); #1;
        end
        obs_rdata = rsp_rdata; obs_err = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge PCLK); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== obs_rdata || rsp_err !== obs_err || cmd_ready !== 1'b0)
                obs_hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        obs_post_valid = rsp_valid; obs_post_ready = cmd_ready;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready); else n_pass++;
        n_checks++; if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b0) $display("FAIL rst_flags: got %b expected 00000", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}); else n_pass++;
        n_checks++; if (PADDR !== 8'h00 || PWDATA !== 32'h0) $display("FAIL rst_bus: got PADDR=%h PWDATA=%h expected 0", PADDR, PWDATA); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rdata: got %h expected 0", rsp_rdata); else n_pass++;
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_write_read();
        model(1'b1, 8'h0C, 32'h7, 0, 1'b0);
        run_cmd(1'b1, 8'h0C, 32'h7, 0, 1'b0, 0);
        n_checks++; if (obs_lat !== 3) $display("FAIL wr_latency: got %0d expected 3", obs_lat); else n_pass++;
        n_checks++; if (obs_setup !== 1 || obs_access !== 1) $display("FAIL wr_phases: got setup=%0d access=%0d expected 1/1", obs_setup, obs_access); else n_pass++;
        n_checks++; if (obs_pwdata !== 32'h7 || obs_pwrite !== 1'b1) $display("FAIL wr_pwdata: got %h/%b expected 00000007/1", obs_pwdata, obs_pwrite); else n_pass++;
        n_checks++; if (obs_err !== 1'b0 || obs_rdata !== 32'h0) $display("FAIL wr_rsp: got err=%b rdata=%h expected 0/0", obs_err, obs_rdata); else n_pass++;
        model(1'b0, 8'h0C, 32'hDEAD_BEEF, 0, 1'b0);
        run_cmd(1'b0, 8'h0C, 32'hDEAD_BEEF, 0, 1'b0, 0);
        n_checks++; if (obs_lat !== 3) $display("FAIL rd_latency: got %0d expected 3", obs_lat); else n_pass++;
        n_checks++; if (obs_rdata !== 32'h7 || obs_err !== 1'b0) $display("FAIL rd_rsp: got rdata=%h err=%b expected 00000007/0", obs_rdata, obs_err); else n_pass++;
        n_checks++; if (obs_pwdata !== 32'h0 || obs_pwrite !== 1'b0) $display("FAIL rd_pwdata: got %h/%b expected 0/0", obs_pwdata, obs_pwrite); else n_pass++;
        n_checks++; if (obs_hs_wait !== 0 || obs_post_ready !== 1'b1) $display("FAIL rd_ready_again: got wait=%0d ready=%b expected 0/1", obs_hs_wait, obs_post_ready); else n_pass++;
    endtask

    task automatic test_wait_states();
        model(1'b1, 8'h1C, 32'h1, 0, 1'b0);
        run_cmd(1'b1, 8'h1C, 32'h1, 0, 1'b0, 0);
        model(1'b0, 8'h1C, 32'h0, 3, 1'b0);
        run_cmd(1'b0, 8'h1C, 32'h0, 3, 1'b0, 0);
        n_checks++; if (obs_access !== 4) $display("FAIL wait_access_len: got %0d expected 4", obs_access); else n_pass++;
        n_checks++; if (obs_lat !== 6) $display("FAIL wait_latency: got %0d expected 6", obs_lat); else n_pass++;
        n_checks++; if (obs_addr_ok !== 1'b1) $display("FAIL wait_paddr_stable: got %b expected 1", obs_addr_ok); else n_pass++;
        n_checks++; if (obs_rdata !== 32'h1 || obs_err !== 1'b0) $display("FAIL wait_rsp: got rdata=%h err=%b expected 00000001/0", obs_rdata, obs_err); else n_pass++;
    endtask

    task automatic test_timeout();
        model(1'b0, 8'h04, 32'h0, 1000, 1'b0);
        run_cmd(1'b0, 8'h04, 32'h0, 1000, 1'b0, 0);
        n_checks++; if (obs_access !== TO) $display("FAIL to_access_len: got %0d expected %0d", obs_access, TO); else n_pass++;
        n_checks++; if (obs_lat !== TO + 2) $display("FAIL to_latency: got %0d expected %0d", obs_lat, TO + 2); else n_pass++;
        n_checks++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0) $display("FAIL to_rsp: got err=%b rdata=%h expected 1/0", obs_err, obs_rdata); else n_pass++;
        model(1'b0, 8'h04, 32'h0, 0, 1'b0);
        run_cmd(1'b0, 8'h04, 32'h0, 0, 1'b0, 0);
        n_checks++; if (obs_lat !== 3 || obs_err !== 1'b0 || obs_access !== 1) $display("FAIL to_next_cmd: got lat=%0d err=%b access=%0d expected 3/0/1", obs_lat, obs_err, obs_access); else n_pass++;
    endtask

    task automatic test_misaligned();
        model(1'b1, 8'h0E, 32'hFFFF_FFFF, 0, 1'b0);
        run_cmd(1'b1, 8'h0E, 32'hFFFF_FFFF, 0, 1'b0, 0);
        n_checks++; if (obs_setup !== 0 || obs_access !== 0) $display("FAIL mis_no_bus: got setup=%0d access=%0d expected 0/0", obs_setup, obs_access); else n_pass++;
        n_checks++; if (obs_lat !== 1) $display("FAIL mis_latency: got %0d expected 1", obs_lat); else n_pass++;
        n_checks++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0) $display("FAIL mis_rsp: got err=%b rdata=%h expected 1/0", obs_err, obs_rdata); else n_pass++;
        model(1'b0, 8'h0C, 32'h0, 0, 1'b1);
        run_cmd(1'b0, 8'h0C, 32'h0, 0, 1'b1, 0);
        n_checks++; if (obs_err !== 1'b1 || obs_rdata !== 32'h7) $display("FAIL slverr_rsp: got err=%b rdata=%h expected 1/00000007", obs_err, obs_rdata); else n_pass++;
    endtask

    task automatic test_backpressure();
        model(1'b1, 8'h08, 32'h15, 0, 1'b0);
        run_cmd(1'b1, 8'h08, 32'h15, 0, 1'b0, 0);
        model(1'b0, 8'h08, 32'h0, 0, 1'b0);
        run_cmd(1'b0, 8'h08, 32'h0, 0, 1'b0, 5);
        n_checks++; if (obs_rdata !== 32'h15 || obs_err !== 1'b0) $display("FAIL bp_rsp: got rdata=%h err=%b expected 00000015/0", obs_rdata, obs_err); else n_pass++;
        n_checks++; if (obs_hold_ok !== 1'b1) $display("FAIL bp_stable: got %b expected 1", obs_hold_ok); else n_pass++;
        n_checks++; if (obs_post_valid !== 1'b0 || obs_post_ready !== 1'b1) $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", obs_post_valid, obs_post_ready); else n_pass++;
    endtask

    task automatic test_reset_during_access();
        int  k;
        bit  quiet;
        sl_wait = 1000; sl_err = 1'b0; rsp_ready = 1'b1;
        cmd_write = 1'b0; cmd_addr = 8'h10; cmd_wdata = 32'h0; cmd_valid = 1'b1;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (!(PSEL === 1'b1 && PENABLE === 1'b1) && k < 5) begin @(posedge PCLK); #1; k++; end
        n_checks++; if (PENABLE !== 1'b1) $display("FAIL rsta_reach_access: got PENABLE=%b expected 1", PENABLE); else n_pass++;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        n_checks++; if ({PSEL, PENABLE, rsp_valid} !== 3'b000) $display("FAIL rsta_bus_drop: got %b expected 000", {PSEL, PENABLE, rsp_valid}); else n_pass++;
        n_checks++; if (PADDR !== 8'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0) $display("FAIL rsta_bus_zero: got %h/%h/%b expected 0", PADDR, PWDATA, PWRITE); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || cmd_ready !== 1'b0) $display("FAIL rsta_rsp_zero: got %h/%b ready=%b expected 0/0/0", rsp_rdata, rsp_err, cmd_ready); else n_pass++;
        PRESET = 1'b0;
        quiet = 1'b1;
        repeat (3) begin
            @(posedge PCLK); #1;
            if (rsp_valid !== 1'b0 || PSEL !== 1'b0 || cmd_ready !== 1'b1) quiet = 1'b0;
        end
        n_checks++; if (quiet !== 1'b1) $display("FAIL rsta_no_replay: got %b expected 1", quiet); else n_pass++;
        model(1'b0, 8'h10, 32'h0, 0, 1'b0);
        run_cmd(1'b0, 8'h10, 32'h0, 0, 1'b0, 0);
        n_checks++; if (obs_setup !== 1 || obs_access !== 1 || obs_lat !== 3) $display("FAIL rsta_clean_cmd: got setup=%0d access=%0d lat=%0d expected 1/1/3", obs_setup, obs_access, obs_lat); else n_pass++;
        n_checks++; if (obs_rdata !== exp_rdata || obs_err !== 1'b0) $display("FAIL rsta_clean_rsp: got %h/%b expected %h/0", obs_rdata, obs_err, exp_rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit          wr, serr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          waits, hold, r;
        for (int i = 0; i < 40; i++) begin
            wr    = 1'($urandom);
            addr  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            wdata = $urandom;
            r     = $urandom_range(0, 9);
            waits = (r == 9) ? TO + $urandom_range(0, 3) : (r == 8) ? TO - 1 : $urandom_range(0, 3);
            serr  = ($urandom_range(0, 7) == 0);
            hold  = $urandom_range(0, 2);
            model(wr, addr, wdata, waits, serr);
            run_cmd(wr, addr, wdata, waits, serr, hold);
            n_checks++; if (obs_lat !== exp_lat) $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, obs_lat, exp_lat); else n_pass++;
            n_checks++; if (obs_setup !== exp_setup || obs_access !== exp_access) $display("FAIL b2b_phases[%0d]: got %0d/%0d expected %0d/%0d", i, obs_setup, obs_access, exp_setup, exp_access); else n_pass++;
            n_checks++; if (obs_err !== exp_err || obs_rdata !== exp_rdata) $display("FAIL b2b_rsp[%0d]: got err=%b rdata=%h expected %b/%h", i, obs_err, obs_rdata, exp_err, exp_rdata); else n_pass++;
            n_checks++; if (obs_hs_wait !== 0 || obs_post_valid !== 1'b0 || obs_post_ready !== 1'b1 || obs_hold_ok !== 1'b1) $display("FAIL b2b_flow[%0d]: got wait=%0d valid=%b ready=%b hold=%b expected 0/0/1/1", i, obs_hs_wait, obs_post_valid, obs_post_ready, obs_hold_ok); else n_pass++;
            if (exp_access > 0) begin
                n_checks++; if (obs_addr_ok !== 1'b1 || obs_pwrite !== wr || obs_pwdata !== (wr ? wdata : 32'h0)) $display("FAIL b2b_bus[%0d]: got addr_ok=%b pwrite=%b pwdata=%h expected 1/%b/%h", i, obs_addr_ok, obs_pwrite, obs_pwdata, wr, wr ? wdata : 32'h0); else n_pass++;
            end
        end
    endtask

    initial begin
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_wait_states();
        test_timeout();
        test_misaligned();
        test_backpressure();
        test_reset_during_access();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
